// File: rtl/eic_input_conditioner_pkg.sv
// Shared constants and the per-cycle decision helper for the EIC input conditioner.
// Latency: n/a (package only).
// Backpressure: none; conditioning evaluates every channel on every cycle.
package eic_input_conditioner_pkg;

  localparam int EIC_CHANNELS     = 8;
  localparam int EIC_SYNC_STAGES  = 2;
  localparam int EIC_FILTER_WIDTH = 8;

  // What one channel does to its output/counter on a given cycle.
  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,  // filter off: follow the synced level directly
    ACT_HOLD   = 2'd1,  // synced level agrees with output: clear run
    ACT_COUNT  = 2'd2,  // disagreement still shorter than the limit
    ACT_TOGGLE = 2'd3   // disagreement lasted long enough: take new level
  } chan_act_e;

  function automatic chan_act_e chan_action(input logic filt_en,
                                            input logic differs,
                                            input logic at_limit);
    if (!filt_en)     return ACT_BYPASS;
    else if (!differs) return ACT_HOLD;
    else if (at_limit) return ACT_TOGGLE;
    else               return ACT_COUNT;
  endfunction

endpackage

// File: rtl/eic_input_conditioner_channel.sv
// One interrupt line: synchronizer chain, stability counter and output register.
// Latency: SYNC_STAGES + L edges filtered (L = max(filter_limit,1)), SYNC_STAGES + 1 bypassed.
// Backpressure: none; a new sample is taken every cycle.
// Ports: CLK/RESET (sync, active-high), raw_in async line, filter_en, filter_limit,
//        signal_out conditioned level, change one-cycle toggle pulse.
module eic_input_conditioner_channel
  import eic_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = EIC_SYNC_STAGES,
  parameter int FILTER_WIDTH = EIC_FILTER_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    raw_in,
  input  logic                    filter_en,
  input  logic [FILTER_WIDTH-1:0] filter_limit,
  output logic                    signal_out,
  output logic                    change
);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    out_q, out_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                    change_q, change_d;

  logic                    sync_lvl;
  logic [FILTER_WIDTH-1:0] eff_limit;
  logic [FILTER_WIDTH-1:0] limit_m1;
  chan_act_e               act;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    sync_lvl = sync_q[SYNC_STAGES-1];

    // A zero limit behaves like one so the filter can never lock up.
    eff_limit = (filter_limit == '0) ? FILTER_WIDTH'(1) : filter_limit;
    limit_m1  = eff_limit - FILTER_WIDTH'(1);

    // '>=' rather than '==': if the limit drops below the running count,
    // the pending toggle happens on the next edge instead of never.
    act = chan_action(filter_en, sync_lvl != out_q, cnt_q >= limit_m1);

    out_d = out_q;
    cnt_d = '0;
    case (act)
      ACT_BYPASS: out_d = sync_lvl;
      ACT_HOLD:   out_d = out_q;
      ACT_COUNT:  cnt_d = cnt_q + FILTER_WIDTH'(1);
      ACT_TOGGLE: out_d = sync_lvl;
      default:    out_d = out_q;
    endcase

    change_d = out_d ^ out_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q   <= '0;
      out_q    <= 1'b0;
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  assign signal_out = out_q;
  assign change     = change_q;

endmodule

// File: rtl/eic_input_conditioner.sv
// Synchronizes and optionally glitch-filters every raw interrupt line feeding the EIC core.
// Latency: SYNC_STAGES + L edges filtered, SYNC_STAGES + 1 bypassed; all outputs registered.
// Backpressure: none; one evaluation per channel per cycle.
// Ports: CLK, RESET (sync, active-high), raw_in[CHANNELS], filter_en[CHANNELS],
//        filter_limit (shared), signal_out[CHANNELS] to core, change[CHANNELS] debug pulses.
module eic_input_conditioner
  import eic_input_conditioner_pkg::*;
#(
  parameter int CHANNELS     = EIC_CHANNELS,
  parameter int SYNC_STAGES  = EIC_SYNC_STAGES,
  parameter int FILTER_WIDTH = EIC_FILTER_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [CHANNELS-1:0]     raw_in,
  input  logic [CHANNELS-1:0]     filter_en,
  input  logic [FILTER_WIDTH-1:0] filter_limit,
  output logic [CHANNELS-1:0]     signal_out,
  output logic [CHANNELS-1:0]     change
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    eic_input_conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_WIDTH (FILTER_WIDTH)
    ) u_chan (
      .CLK          (CLK),
      .RESET        (RESET),
      .raw_in       (raw_in[i]),
      .filter_en    (filter_en[i]),
      .filter_limit (filter_limit),
      .signal_out   (signal_out[i]),
      .change       (change[i])
    );
  end

endmodule
